ifu_fetch: RTL and testbench

//  Instruction fetch stage. Sequenced by the core controller through an en/finish handshake.
//  On i_en it reads one 32-bit instruction from the instruction bus at the fetch PC.
//  It then presents the instruction and its PC to the decode stage and pulses o_finish.
//  It owns the fetch PC: +4 after each fetch, or a redirect supplied by the execute stage.

---
 rtl/ifu_fetch.sv | 173 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one 32-bit bus read per en/finish handshake,
// owning the fetch PC (+4 sequencing or execute-stage redirect).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_finish,
  input  logic        i_pc_wr,
  input  logic [31:0] i_pc_wdata,
  output logic        o_ibus_req,
  output logic [31:0] o_ibus_addr,
  input  logic        i_ibus_ack,
  input  logic        i_ibus_err,
  input  logic [31:0] i_ibus_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic        finish_q, finish_d;

  logic [31:0] eff_pc;
  logic        rd_vld;
  logic [31:0] rd_pc;
  logic        req_done;
  logic        req_ok;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    finish_d   = 1'b0;
    req_done   = 1'b0;
    req_ok     = 1'b0;

    // A same-cycle redirect beats an older pending one.
    rd_vld = i_pc_wr | pend_vld_q;
    rd_pc  = i_pc_wr ? i_pc_wdata : pend_pc_q;
    eff_pc = rd_vld ? rd_pc : fetch_pc_q;

    unique case (state_q)
      S_IDLE: begin
        fetch_pc_d = eff_pc;
        pend_vld_d = 1'b0;
        if (i_en) begin
          if (eff_pc[1:0] != 2'b00) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
            fault_d  = 1'b1;
            cause_d  = 2'd1;
            inst_d   = NOP;
            pc_d     = eff_pc;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = eff_pc;
            cnt_d   = '0;
            fault_d = 1'b0;
            cause_d = 2'd0;
          end
        end
      end
      S_REQ: begin
        if (i_pc_wr) begin
          pend_pc_d  = i_pc_wdata;
          pend_vld_d = 1'b1;
        end
        if (i_ibus_err) begin
          req_done = 1'b1;
          fault_d  = 1'b1;
          cause_d  = 2'd2;
          inst_d   = NOP;
        end else if (i_ibus_ack) begin
          req_done = 1'b1;
          req_ok   = 1'b1;
          fault_d  = 1'b0;
          cause_d  = 2'd0;
          inst_d   = i_ibus_rdata;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          req_done = 1'b1;
          fault_d  = 1'b1;
          cause_d  = 2'd3;
          inst_d   = NOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (req_done) begin
          state_d    = S_DONE;
          finish_d   = 1'b1;
          req_d      = 1'b0;
          pc_d       = fetch_pc_q;
          pend_vld_d = 1'b0;
          if (rd_vld)      fetch_pc_d = rd_pc;
          else if (req_ok) fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (i_pc_wr) begin
          pend_pc_d  = i_pc_wdata;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      inst_q     <= NOP;
      pc_q       <= '0;
      fault_q    <= 1'b0;
      cause_q    <= 2'd0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      finish_q   <= finish_d;
    end
  end

  assign o_finish      = finish_q;
  assign o_ibus_req    = req_q;
  assign o_ibus_addr   = addr_q;
  assign o_inst        = inst_q;
  assign o_pc          = pc_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a vector table of fetches plus hand-written
// sequences for same-edge redirect, reset mid-fetch and bus timeout.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, pc_wr, ack, err;
  logic [31:0] pc_wdata, rdata;
  logic        finish, req, fault;
  logic [31:0] addr, inst, pc;
  logic [1:0]  cause;

  logic        en2, ack2;
  logic        finish2, req2, fault2;
  logic [31:0] addr2, inst2, pc2;
  logic [1:0]  cause2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ifu_fetch u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_finish(finish),
    .i_pc_wr(pc_wr), .i_pc_wdata(pc_wdata),
    .o_ibus_req(req), .o_ibus_addr(addr),
    .i_ibus_ack(ack), .i_ibus_err(err), .i_ibus_rdata(rdata),
    .o_inst(inst), .o_pc(pc), .o_fault(fault), .o_fault_cause(cause)
  );

  ifu_fetch #(.RESET_PC(32'h0000_0040), .TIMEOUT(8'd4)) u_dut_to (
    .i_clk(clk), .i_rst(rst), .i_en(en2), .o_finish(finish2),
    .i_pc_wr(1'b0), .i_pc_wdata(32'h0),
    .o_ibus_req(req2), .o_ibus_addr(addr2),
    .i_ibus_ack(ack2), .i_ibus_err(1'b0), .i_ibus_rdata(32'hCAFE_0001),
    .o_inst(inst2), .o_pc(pc2), .o_fault(fault2), .o_fault_cause(cause2)
  );

  typedef struct {
    logic        redir;
    logic [31:0] redir_pc;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic stable;
    if (v.redir) begin
      pc_wr = 1'b1; pc_wdata = v.redir_pc;
      tick();
      pc_wr = 1'b0;
    end
    en = 1'b1;
    tick();
    if (v.exp_req) begin
      chk($sformatf("v%0d req", idx), {31'b0, req}, 32'd1);
      chk($sformatf("v%0d addr", idx), addr, v.exp_addr);
      chk($sformatf("v%0d early_finish", idx), {31'b0, finish}, 32'd0);
      stable = 1'b1;
      for (int k = 0; k < v.lat; k++) begin
        tick();
        if (req !== 1'b1 || addr !== v.exp_addr || finish !== 1'b0) stable = 1'b0;
      end
      chk($sformatf("v%0d req_stable", idx), {31'b0, stable}, 32'd1);
      ack = 1'b1; err = v.err; rdata = v.rdata;
      tick();
      ack = 1'b0; err = 1'b0; rdata = '0;
    end
    chk($sformatf("v%0d finish", idx), {31'b0, finish}, 32'd1);
    chk($sformatf("v%0d req_low", idx), {31'b0, req}, 32'd0);
    chk($sformatf("v%0d inst", idx), inst, v.exp_inst);
    chk($sformatf("v%0d pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d fault", idx), {31'b0, fault}, {31'b0, v.exp_fault});
    chk($sformatf("v%0d cause", idx), {30'b0, cause}, {30'b0, v.exp_cause});
    en = 1'b0;
    tick();
    chk($sformatf("v%0d finish_pulse", idx), {31'b0, finish}, 32'd0);
  endtask

  initial begin
    //        redir redir_pc       lat err rdata          req addr           inst           pc             flt cause
    vecs[0]  = '{1'b0, 32'h0,        1, 1'b0, 32'h0050_0093, 1'b1, 32'h0000_0000, 32'h0050_0093, 32'h0000_0000, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 32'h0,        0, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0000_0004, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 32'h0,        3, 1'b0, 32'h2222_2222, 1'b1, 32'h0000_0008, 32'h2222_2222, 32'h0000_0008, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 32'h0,        7, 1'b0, 32'h3333_3333, 1'b1, 32'h0000_000C, 32'h3333_3333, 32'h0000_000C, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 2, 1'b0, 32'h4444_4444, 1'b1, 32'h0000_0100, 32'h4444_4444, 32'h0000_0100, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 32'h0000_0102, 0, 1'b0, 32'h0,         1'b0, 32'h0,         NOP,           32'h0000_0102, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 32'h0,        0, 1'b0, 32'h0,         1'b0, 32'h0,         NOP,           32'h0000_0102, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 32'h0000_0200, 1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0200, NOP,           32'h0000_0200, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 32'h0,        0, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_0200, 32'h5555_5555, 32'h0000_0200, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 1, 1'b0, 32'h6666_6666, 1'b1, 32'hFFFF_FFFC, 32'h6666_6666, 32'hFFFF_FFFC, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 32'h0,        0, 1'b0, 32'h7777_7777, 1'b1, 32'h0000_0000, 32'h7777_7777, 32'h0000_0000, 1'b0, 2'd0};

    rst = 1'b1; en = 1'b0; pc_wr = 1'b0; pc_wdata = '0;
    ack = 1'b0; err = 1'b0; rdata = '0; en2 = 1'b0; ack2 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst finish", {31'b0, finish}, 32'd0);
    chk("rst req", {31'b0, req}, 32'd0);
    chk("rst addr", addr, 32'h0);
    chk("rst inst", inst, NOP);
    chk("rst pc", pc, 32'h0);
    chk("rst fault", {29'b0, fault, cause}, 32'h0);
    chk("rst2 req", {31'b0, req2}, 32'd0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Pending redirect during REQ overwritten by a same-edge-as-ack redirect.
    en = 1'b1;
    tick();
    chk("rdr addr", addr, 32'h0000_0004);
    pc_wr = 1'b1; pc_wdata = 32'h0000_0500;
    tick();
    pc_wdata = 32'h0000_0200; ack = 1'b1; rdata = 32'h8888_8888;
    tick();
    pc_wr = 1'b0; ack = 1'b0; en = 1'b0;
    chk("rdr finish", {31'b0, finish}, 32'd1);
    chk("rdr inst", inst, 32'h8888_8888);
    chk("rdr pc", pc, 32'h0000_0004);
    tick();
    en = 1'b1;
    tick();
    chk("rdr next addr", addr, 32'h0000_0200);
    ack = 1'b1; rdata = 32'h9999_9999;
    tick();
    ack = 1'b0; en = 1'b0;
    chk("rdr next pc", pc, 32'h0000_0200);
    tick();

    // Reset while in REQ; a late ack must not complete anything.
    en = 1'b1;
    tick();
    chk("mid req", {31'b0, req}, 32'd1);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid rst req", {31'b0, req}, 32'd0);
    chk("mid rst addr", addr, 32'h0);
    ack = 1'b1; rdata = 32'hBAD0_BAD0;
    tick();
    ack = 1'b0;
    chk("late ack finish", {31'b0, finish}, 32'd0);
    tick();
    chk("late ack finish2", {31'b0, finish}, 32'd0);
    chk("late ack inst", inst, NOP);
    en = 1'b1;
    tick();
    chk("post rst addr", addr, 32'h0);
    ack = 1'b1; rdata = 32'h0000_0ABC;
    tick();
    ack = 1'b0; en = 1'b0;
    chk("post rst finish", {31'b0, finish}, 32'd1);
    chk("post rst inst", inst, 32'h0000_0ABC);
    tick();

    // Timeout instance: request held exactly TIMEOUT=4 cycles.
    en2 = 1'b1;
    tick();
    chk("to addr", addr2, 32'h0000_0040);
    chk("to req", {31'b0, req2}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("to req hold%0d", k), {30'b0, req2, finish2}, 32'd2);
    end
    tick();
    en2 = 1'b0;
    chk("to finish", {31'b0, finish2}, 32'd1);
    chk("to req low", {31'b0, req2}, 32'd0);
    chk("to cause", {29'b0, fault2, cause2}, {29'b0, 1'b1, 2'd3});
    chk("to inst", inst2, NOP);
    chk("to pc", pc2, 32'h0000_0040);
    tick();
    en2 = 1'b1;
    tick();
    chk("to retry addr", addr2, 32'h0000_0040);
    chk("to retry fault clr", {29'b0, fault2, cause2}, 32'h0);
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0; en2 = 1'b0;
    chk("to retry inst", inst2, 32'hCAFE_0001);
    chk("to retry finish", {31'b0, finish2}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
